// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared types, sprite geometry and colours for the player draw controller
package player_pkg;

    typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} state_e;
    typedef enum logic [1:0] {NONE, POS, NEG} dir_e;

    localparam int SPRITE_W      = 2;
    localparam int SPRITE_H      = 4;
    localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;

    localparam logic [2:0] SHIP_COLOUR_DEFAULT = 3'b111;
    localparam logic [2:0] BG_COLOUR_DEFAULT   = 3'b000;
    localparam logic [6:0] Y_MAX_DEFAULT       = 7'd119;

    // A move is dropped when it would push the 4-row footprint off either screen edge.
    function automatic dir_e decode_dir(input logic pos, input logic neg,
                                        input logic [6:0] y, input logic [6:0] y_top_max);
        dir_e d;
        d = NONE;
        if (pos && !neg && (y < y_top_max)) d = POS;
        if (neg && !pos && (y > 7'd0))      d = NEG;
        return d;
    endfunction

endpackage

// File: rtl/sprite_sweep_counter.sv
// rtl/sprite_sweep_counter.sv - 8-pixel footprint sweep with registered add_x/add_y offsets
module sprite_sweep_counter
    import player_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       add_x,
    output logic [1:0] add_y
);

    localparam logic [2:0] LAST_IDX = 3'(SPRITE_PIXELS - 1);

    logic [2:0] idx_q, idx_d;
    logic       active_q, active_d;
    logic       add_x_q, add_x_d;
    logic [1:0] add_y_q, add_y_d;

    always_comb begin
        idx_d    = idx_q;
        active_d = active_q;
        if (start) begin
            idx_d    = 3'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (idx_q == LAST_IDX) begin
                idx_d    = 3'd0;
                active_d = 1'b0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
        // Offsets are registered from the next index so they line up with the registered plot.
        add_x_d = active_d ? idx_d[0]   : 1'b0;
        add_y_d = active_d ? idx_d[2:1] : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= 3'd0;
            active_q <= 1'b0;
            add_x_q  <= 1'b0;
            add_y_q  <= 2'd0;
        end else begin
            idx_q    <= idx_d;
            active_q <= active_d;
            add_x_q  <= add_x_d;
            add_y_q  <= add_y_d;
        end
    end

    assign done  = active_q && (idx_q == LAST_IDX);
    assign add_x = add_x_q;
    assign add_y = add_y_q;

endmodule

// File: rtl/player_draw_ctrl.sv
// rtl/player_draw_ctrl.sv - per-frame erase/move/draw sequencer; PLAYER_DRAW_CTRL_STATIC_SKIP_EN skips idle redraws
module player_draw_ctrl
    import player_pkg::*;
#(
    parameter logic [2:0] SHIP_COLOUR = SHIP_COLOUR_DEFAULT,
    parameter logic [2:0] BG_COLOUR   = BG_COLOUR_DEFAULT,
    parameter logic [6:0] Y_MAX       = Y_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_pos,
    input  logic       move_neg,
    output logic       add_x,
    output logic [1:0] add_y,
    output logic       y_pos_mod,
    output logic       y_neg_mod,
    output logic       plot,
    output logic [2:0] colour,
    output logic       busy
);

    localparam logic [6:0] Y_TOP_MAX = Y_MAX - 7'd3;

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic       pending_q, pending_d;
    logic [6:0] y_shadow_q, y_shadow_d;
    logic       sweep_start, sweep_done;
    logic       plot_q, y_pos_mod_q, y_neg_mod_q, busy_q;
    logic [2:0] colour_q;
`ifdef PLAYER_DRAW_CTRL_STATIC_SKIP_EN
    logic       drawn_q, drawn_d;
`endif

    sprite_sweep_counter u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (sweep_start),
        .done  (sweep_done),
        .add_x (add_x),
        .add_y (add_y)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pending_d   = pending_q;
        y_shadow_d  = y_shadow_q;
        sweep_start = 1'b0;
`ifdef PLAYER_DRAW_CTRL_STATIC_SKIP_EN
        drawn_d     = drawn_q;
`endif
        // One-deep: extra ticks while busy collapse into the same pending request.
        if (frame_tick && (state_q != IDLE)) pending_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (frame_tick || pending_q) begin
                    pending_d = 1'b0;
                    dir_d     = decode_dir(move_pos, move_neg, y_shadow_q, Y_TOP_MAX);
`ifdef PLAYER_DRAW_CTRL_STATIC_SKIP_EN
                    if (!(dir_d == NONE && drawn_q)) begin
                        state_d     = ERASE;
                        sweep_start = 1'b1;
                    end
`else
                    state_d     = ERASE;
                    sweep_start = 1'b1;
`endif
                end
            end
            ERASE: begin
                if (sweep_done) begin
                    state_d = MOVE;
                    if (dir_q == POS) y_shadow_d = y_shadow_q + 7'd1;
                    if (dir_q == NEG) y_shadow_d = y_shadow_q - 7'd1;
                end
            end
            MOVE: begin
                state_d     = DRAW;
                sweep_start = 1'b1;
            end
            DRAW: begin
                if (sweep_done) begin
                    state_d = IDLE;
`ifdef PLAYER_DRAW_CTRL_STATIC_SKIP_EN
                    drawn_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= NONE;
            pending_q   <= 1'b0;
            y_shadow_q  <= 7'd0;
            plot_q      <= 1'b0;
            colour_q    <= BG_COLOUR;
            y_pos_mod_q <= 1'b0;
            y_neg_mod_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PLAYER_DRAW_CTRL_STATIC_SKIP_EN
            drawn_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            y_shadow_q  <= y_shadow_d;
            plot_q      <= (state_d == ERASE) || (state_d == DRAW);
            colour_q    <= (state_d == DRAW) ? SHIP_COLOUR : BG_COLOUR;
            y_pos_mod_q <= (state_d == MOVE) && (dir_d == POS);
            y_neg_mod_q <= (state_d == MOVE) && (dir_d == NEG);
            busy_q      <= (state_d != IDLE);
`ifdef PLAYER_DRAW_CTRL_STATIC_SKIP_EN
            drawn_q     <= drawn_d;
`endif
        end
    end

    assign plot      = plot_q;
    assign colour    = colour_q;
    assign y_pos_mod = y_pos_mod_q;
    assign y_neg_mod = y_neg_mod_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_player_draw_ctrl.sv
// tb/tb_player_draw_ctrl.sv - randomized bench for player_draw_ctrl against a queue-of-frames model
module tb_player_draw_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame_tick, move_pos, move_neg;
    logic       add_x, y_pos_mod, y_neg_mod, plot, busy;
    logic [1:0] add_y;
    logic [2:0] colour;

    player_draw_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .move_pos   (move_pos),
        .move_neg   (move_neg),
        .add_x      (add_x),
        .add_y      (add_y),
        .y_pos_mod  (y_pos_mod),
        .y_neg_mod  (y_neg_mod),
        .plot       (plot),
        .colour     (colour),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       plot;
        logic [2:0] colour;
        logic       ax;
        logic [1:0] ay;
        logic       yp;
        logic       yn;
        logic       busy;
    } exp_t;

    exp_t q[$];
    exp_t cur, nxt;
    int   checks = 0;
    int   errors = 0;
    int   y_m = 0;
    bit   pending_m = 0;
    bit   drawn_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [2:0] c, input int ax, input int ay,
                                input logic yp, input logic yn, input logic b);
        exp_t e;
        e.plot = p; e.colour = c; e.ax = ax[0]; e.ay = ay[1:0];
        e.yp = yp; e.yn = yn; e.busy = b;
        return e;
    endfunction

    // A frame is a list of 17 output cycles: 8 erase pixels, a move slot, 8 draw pixels.
    task automatic model_edge(input logic rst, input logic tick, input logic pos, input logic neg);
        int d;
        exp_t idle;
        idle = mk(0, 3'b000, 0, 0, 0, 0, 0);
        if (rst) begin
            q.delete();
            pending_m = 0; y_m = 0; drawn_m = 0;
            nxt = idle;
        end else if (cur.busy) begin
            if (tick) pending_m = 1;
            if (q.size() == 0) begin
                nxt = idle;
                drawn_m = 1;
            end else begin
                nxt = q.pop_front();
            end
        end else if (tick || pending_m) begin
            pending_m = 0;
            d = 0;
            if (pos && !neg && y_m < 116) d = 1;
            if (neg && !pos && y_m > 0)   d = 2;
`ifdef PLAYER_DRAW_CTRL_STATIC_SKIP_EN
            if (d == 0 && drawn_m) begin
                nxt = idle;
            end else begin
`else
            begin
`endif
                for (int i = 0; i < 8; i++) q.push_back(mk(1, 3'b000, i % 2, i / 2, 0, 0, 1));
                q.push_back(mk(0, 3'b000, 0, 0, d == 1, d == 2, 1));
                for (int i = 0; i < 8; i++) q.push_back(mk(1, 3'b111, i % 2, i / 2, 0, 0, 1));
                nxt = q.pop_front();
            end
        end else begin
            nxt = idle;
        end
        if (nxt.yp) y_m++;
        if (nxt.yn) y_m--;
        cur = nxt;
    endtask

    task automatic cycle(input logic rst, input logic tick, input logic pos, input logic neg);
        @(negedge clk);
        reset = rst; frame_tick = tick; move_pos = pos; move_neg = neg;
        @(posedge clk);
        model_edge(rst, tick, pos, neg);
        #1;
        check("plot",      plot,      cur.plot);
        check("colour",    colour,    cur.colour);
        check("add_x",     add_x,     cur.ax);
        check("add_y",     add_y,     cur.ay);
        check("y_pos_mod", y_pos_mod, cur.yp);
        check("y_neg_mod", y_neg_mod, cur.yn);
        check("busy",      busy,      cur.busy);
    endtask

    initial begin
        cur = mk(0, 3'b000, 0, 0, 0, 0, 0);
        reset = 1; frame_tick = 0; move_pos = 0; move_neg = 0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // plain frame, then neg at y=0, then both requested
        cycle(0, 1, 0, 0);
        repeat (19) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 1);
        repeat (19) cycle(0, 0, 0, 1);
        cycle(0, 1, 1, 1);
        repeat (19) cycle(0, 0, 1, 1);

        // pos from y=0, then three ticks inside one busy window incl. the last draw cycle
        cycle(0, 1, 1, 0);
        repeat (19) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 1; i <= 17; i++) cycle(0, (i == 3 || i == 9 || i == 17), 0, 0);
        repeat (40) cycle(0, 0, 0, 0);

        // reset while erasing pixel 4
        cycle(0, 1, 1, 0);
        repeat (4) cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        repeat (25) cycle(0, 0, 0, 0);

        // walk to the bottom limit and past it
        for (int i = 0; i < 125 * 18; i++) cycle(0, 1, 1, 0);
        repeat (20) cycle(0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 1500; i++)
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        repeat (20) cycle(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
